// File: rtl/conta_seq_checker.sv
// -----------------------------------------------------------------------------
// conta_seq_checker
//
// Receive-side sequence checker for the tt_um_conta count stream. It seeds on
// the first valid sample, locks after LOCK_CNT consecutive correct increments,
// then counts every out-of-sequence sample as an error. FAULT_LIMIT
// consecutive misses while locked park the checker in FAULT.
//
// Optional feature (macro CONTA_CHK_RESYNC_EN):
//   defined   - a valid sample in FAULT reseeds and returns to ACQUIRE,
//               keeping err_count.
//   undefined - FAULT is sticky until clear or rst.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   clear         synchronous clear back to IDLE (drops any same-cycle sample)
//   sample_valid  sample is valid this cycle
//   sample        observed counter value (WIDTH bits)
//   locked        checker is in LOCKED
//   fault         checker is in FAULT
//   err_pulse     one-cycle strobe per counted error
//   err_count     saturating error total (ERR_W bits)
//   expected      next predicted value (WIDTH bits)
// -----------------------------------------------------------------------------
module conta_seq_checker #(
    parameter int WIDTH       = 3,
    parameter int ERR_W       = 8,
    parameter int LOCK_CNT    = 4,
    parameter int FAULT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             locked,
    output logic             fault,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam int RUN_W  = (LOCK_CNT    < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int MISS_W = (FAULT_LIMIT < 1) ? 1 : $clog2(FAULT_LIMIT + 1);

    localparam logic [RUN_W-1:0]  LOCK_TGT  = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] FAULT_TGT = MISS_W'(FAULT_LIMIT);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    state_t             state;
    logic [WIDTH-1:0]   last;
    logic [RUN_W-1:0]   run;
    logic [MISS_W-1:0]  miss;

    // Next-value helpers; all arithmetic wraps naturally at the register width,
    // so 7 -> 0 is a legal increment for WIDTH=3.
    logic [WIDTH-1:0]   sample_inc;
    logic [RUN_W-1:0]   run_inc;
    logic [MISS_W-1:0]  miss_inc;
    logic               is_hold;
    logic               is_match;

    always_comb begin
        sample_inc = sample + WIDTH'(1);
        run_inc    = run + RUN_W'(1);
        miss_inc   = miss + MISS_W'(1);
        // A repeat of the previous value means the counter was stalled
        // (enable low); it is neither progress nor an error.
        is_hold    = (sample == last);
        is_match   = (sample == expected);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= '0;
            run       <= '0;
            miss      <= '0;
            expected  <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
            fault     <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            last      <= '0;
            run       <= '0;
            miss      <= '0;
            expected  <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            // Strobe by default; only a counted mismatch raises it again.
            err_pulse <= 1'b0;
            if (sample_valid) begin
                case (state)
                    IDLE: begin
                        last     <= sample;
                        expected <= sample_inc;
                        run      <= '0;
                        state    <= ACQUIRE;
                    end

                    ACQUIRE: begin
                        if (!is_hold) begin
                            last     <= sample;
                            expected <= sample_inc;
                            if (is_match) begin
                                run <= run_inc;
                                if (run_inc == LOCK_TGT) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                    miss   <= '0;
                                end
                            end else begin
                                // Not locked yet: just restart the run from
                                // this sample, no error is charged.
                                run <= '0;
                            end
                        end
                    end

                    LOCKED: begin
                        if (!is_hold) begin
                            // Reseed on both outcomes so a single glitch costs
                            // one error rather than a cascade.
                            last     <= sample;
                            expected <= sample_inc;
                            if (is_match) begin
                                miss <= '0;
                            end else begin
                                err_pulse <= 1'b1;
                                if (err_count != ERR_MAX)
                                    err_count <= err_count + ERR_W'(1);
                                miss <= miss_inc;
                                if (miss_inc == FAULT_TGT) begin
                                    state  <= FAULT;
                                    fault  <= 1'b1;
                                    locked <= 1'b0;
                                end
                            end
                        end
                    end

                    FAULT: begin
`ifdef CONTA_CHK_RESYNC_EN
                        // Resync: treat the sample like a fresh seed but keep
                        // the error history.
                        last     <= sample;
                        expected <= sample_inc;
                        run      <= '0;
                        state    <= ACQUIRE;
                        fault    <= 1'b0;
`endif
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conta_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_conta_seq_checker
//
// Directed-vector bench for conta_seq_checker. Two instances share stimulus:
// u_dut uses default parameters, u_sat uses ERR_W=2 to observe saturation.
// Expected values are hand-derived per step.
// -----------------------------------------------------------------------------
module tb_conta_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       sample_valid = 1'b0;
    logic [2:0] sample = '0;

    logic       locked, fault, err_pulse;
    logic [7:0] err_count;
    logic [2:0] expected;

    logic       s_locked, s_fault, s_err_pulse;
    logic [1:0] s_err_count;
    logic [2:0] s_expected;

    int n_chk = 0;
    int n_err = 0;
    int sat_pulses = 0;
    int main_pulses = 0;

    always #5 clk = ~clk;

    conta_seq_checker u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .sample_valid(sample_valid), .sample(sample),
        .locked(locked), .fault(fault), .err_pulse(err_pulse),
        .err_count(err_count), .expected(expected)
    );

    conta_seq_checker #(.ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .clear(clear),
        .sample_valid(sample_valid), .sample(sample),
        .locked(s_locked), .fault(s_fault), .err_pulse(s_err_pulse),
        .err_count(s_err_count), .expected(s_expected)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge; return 1ns after the
    // rising edge so outputs are sampled clear of the edge.
    task automatic step(input logic v, input logic [2:0] s, input logic c);
        @(negedge clk);
        sample_valid = v;
        sample       = s;
        clear        = c;
        @(posedge clk);
        #1;
        if (s_err_pulse) sat_pulses++;
        if (err_pulse)   main_pulses++;
    endtask

    initial begin
        logic [2:0] e;

        // ---- reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_count", err_count, 0);
        chk("rst_expected", expected, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- lock and wrap: 5,6,7,0,1,2
        step(1, 3'd5, 0);
        chk("seed_expected", expected, 6);
        chk("seed_locked", locked, 0);
        step(1, 3'd6, 0);
        step(1, 3'd7, 0);
        step(1, 3'd0, 0);
        chk("pre_lock", locked, 0);
        step(1, 3'd1, 0);
        chk("lock_rise", locked, 1);
        step(1, 3'd2, 0);
        chk("wrap_expected", expected, 3);
        chk("wrap_count", err_count, 0);

        // ---- idle cycle changes nothing
        step(0, 3'd6, 0);
        chk("idle_expected", expected, 3);
        chk("idle_locked", locked, 1);

        // ---- stall tolerance: 3,3,3,4
        step(1, 3'd3, 0);
        step(1, 3'd3, 0);
        chk("stall_pulse", err_pulse, 0);
        chk("stall_expected", expected, 4);
        step(1, 3'd3, 0);
        step(1, 3'd4, 0);
        chk("stall_end_exp", expected, 5);
        chk("stall_end_lock", locked, 1);
        chk("stall_count", err_count, 0);

        // ---- single error: 4 (stall), 6 (miss), 7 (match)
        step(1, 3'd4, 0);
        chk("se_hold_pulse", err_pulse, 0);
        step(1, 3'd6, 0);
        chk("se_pulse", err_pulse, 1);
        chk("se_count", err_count, 1);
        chk("se_expected", expected, 7);
        step(1, 3'd7, 0);
        chk("se_pulse_drop", err_pulse, 0);
        chk("se_locked", locked, 1);
        chk("se_expected2", expected, 0);

        // ---- fault entry: bring expected to 2, then 5,0,6
        step(1, 3'd0, 0);
        step(1, 3'd1, 0);
        chk("fe_expected", expected, 2);
        step(1, 3'd5, 0);
        chk("fe_pulse1", err_pulse, 1);
        chk("fe_fault1", fault, 0);
        step(1, 3'd0, 0);
        chk("fe_pulse2", err_pulse, 1);
        chk("fe_locked2", locked, 1);
        step(1, 3'd6, 0);
        chk("fe_pulse3", err_pulse, 1);
        chk("fe_count", err_count, 4);
        chk("fe_fault", fault, 1);
        chk("fe_locked", locked, 0);
        chk("fe_sat_count", s_err_count, 3);

        // ---- sample while in FAULT
        step(1, 3'd1, 0);
`ifdef CONTA_CHK_RESYNC_EN
        chk("fr_fault", fault, 0);
        chk("fr_expected", expected, 2);
`else
        chk("fs_fault", fault, 1);
        chk("fs_expected", expected, 7);
`endif
        chk("f_locked", locked, 0);
        chk("f_pulse", err_pulse, 0);
        chk("f_count", err_count, 4);

        // ---- clear together with a valid sample
        step(1, 3'd3, 1);
        chk("clr_count", err_count, 0);
        chk("clr_expected", expected, 0);
        chk("clr_fault", fault, 0);
        chk("clr_locked", locked, 0);
        // 4 seeds from IDLE; lock needs four increments after it, so a
        // sample leaked through clear would lock one step early.
        step(1, 3'd4, 0);
        chk("clr_seed_exp", expected, 5);
        step(1, 3'd5, 0);
        step(1, 3'd6, 0);
        step(1, 3'd7, 0);
        chk("clr_prelock", locked, 0);
        step(1, 3'd0, 0);
        chk("clr_lock", locked, 1);

        // ---- saturation: 5 isolated errors while locked
        sat_pulses  = 0;
        main_pulses = 0;
        e = 3'd1;
        for (int i = 0; i < 5; i++) begin
            step(1, e + 3'd2, 0);
            chk("sat_err_pulse", s_err_pulse, 1);
            e = e + 3'd3;
            step(1, e, 0);
            chk("sat_still_locked", locked, 1);
            e = e + 3'd1;
        end
        chk("sat_main_count", err_count, 5);
        chk("sat_count", s_err_count, 3);
        chk("sat_pulses", sat_pulses, 5);
        chk("main_pulses", main_pulses, 5);
        chk("sat_fault", s_fault, 0);

        // ---- asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_count", err_count, 0);
        chk("arst_expected", expected, 0);
        chk("arst_sat_count", s_err_count, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 3'd2, 0);
        chk("post_rst_exp", expected, 3);
        chk("post_rst_lock", locked, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
